pipe_stage_skid: RTL

//  Generic pipeline stage register with valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipe_stage_skid_if.sv | 30 +++
 rtl/pipe_stage_skid.sv | 113 +++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for pipe_stage_skid: upstream (in_*) and downstream (out_*) channels.
// slave is the stage's view; master is the surrounding pipeline's view.
interface pipe_stage_skid_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and sync flush.
// Optional perf counters (stall_cnt, xfer_cnt) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int unsigned      CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   pipe_stage_skid_if.slave     bus
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic [CNT_WIDTH-1:0] xfer_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             out_valid_q;
   logic             in_ready_q;
   logic             in_fire;
   logic             out_fire;

   if (CNT_WIDTH < 1) begin : g_bad_cnt_width
      $error("pipe_stage_skid: CNT_WIDTH must be at least 1");
   end

   assign in_fire       = bus.in_valid & in_ready_q;
   assign out_fire      = out_valid_q & bus.out_ready;
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = main_q;

   // in_ready/out_valid are registered copies of the next state so no comb path crosses the stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= EMPTY;
         main_q      <= RESET_VAL;
         skid_q      <= RESET_VAL;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else if (flush) begin
         state       <= EMPTY;
         main_q      <= RESET_VAL;
         skid_q      <= RESET_VAL;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         in_ready_q <= (state != TWO);
         unique case (state)
            EMPTY: begin
               if (in_fire) begin
                  main_q      <= bus.in_data;
                  state       <= ONE;
                  out_valid_q <= 1'b1;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_q <= bus.in_data;
               end else if (in_fire) begin
                  skid_q     <= bus.in_data;
                  state      <= TWO;
                  in_ready_q <= 1'b0;
               end else if (out_fire) begin
                  state       <= EMPTY;
                  out_valid_q <= 1'b0;
               end
            end
            TWO: begin
               // Skid entry moves up behind the departing head, keeping FIFO order.
               if (out_fire) begin
                  main_q     <= skid_q;
                  state      <= ONE;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state       <= EMPTY;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   // Saturating counters; flush leaves them untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         xfer_cnt  <= '0;
      end else begin
         if (out_valid_q && !bus.out_ready && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
         end
         if (out_fire && (xfer_cnt != {CNT_WIDTH{1'b1}})) begin
            xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
         end
      end
   end
`endif

endmodule
